// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle N-bit unsigned subtractor.
// Computes {borrow, diff} = {1'b0,a} - {1'b0,b} one W-bit slice per clock,
// rippling the borrow between slices, with valid/ready on both sides.
// Optional macro SERIAL_SUB_SATURATE_EN: clamp diff to 0 when the result borrows.
module serial_subtractor #(
  parameter int N = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow
);
  // Slice count, padded operand width and slice counter width.
  localparam int S  = (N + W - 1) / W;
  localparam int PW = S * W;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  if (N < 1 || N > 32 || W < 1 || W > N) begin : g_param_check
    $error("serial_subtractor: N must be 1..32 and W must be 1..N");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] a_sh;
  logic [PW-1:0] b_sh;
  logic [CW-1:0] cnt;
  logic [N-1:0]  diff_r;
  logic [N-1:0]  diff_upd;
  logic          bor_r;
  logic [W-1:0]  slice_d;
  logic          slice_b;
  logic          last;
  logic          accept;

  // One slice of subtract-with-borrow; the top bit of the W+1 result is the borrow-out.
  function automatic logic [W:0] sub_slice(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bin);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
  endfunction

`ifdef SERIAL_SUB_SATURATE_EN
  // Clamp an underflowing difference to zero.
  function automatic logic [N-1:0] sat_diff(input logic [N-1:0] d, input logic bout);
    return bout ? '0 : d;
  endfunction
`endif

  assign {slice_b, slice_d} = sub_slice(a_sh[W-1:0], b_sh[W-1:0], bor_r);
  assign last   = (cnt == CW'(S - 1));
  assign accept = (state == IDLE) && in_valid;
  assign diff   = diff_r;
  assign borrow = bor_r;

  // Merge the current slice result into the bits of diff it covers; padding bits are dropped.
  always_comb begin
    diff_upd = diff_r;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i / W)) diff_upd[i] = slice_d[i % W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters: the active slice always sits in the low W bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= PW'(a);
      b_sh <= PW'(b);
    end else if (state == RUN) begin
      a_sh <= a_sh >> W;
      b_sh <= b_sh >> W;
    end
  end

  // Slice counter, running borrow and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      bor_r  <= 1'b0;
      diff_r <= '0;
    end else if (accept) begin
      cnt   <= '0;
      bor_r <= 1'b0;
    end else if (state == RUN) begin
      bor_r <= slice_b;
      if (last) begin
`ifdef SERIAL_SUB_SATURATE_EN
        diff_r <= sat_diff(diff_upd, slice_b);
`else
        diff_r <= diff_upd;
`endif
      end else begin
        cnt    <= cnt + CW'(1);
        diff_r <= diff_upd;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: table-driven vectors plus hand-written
// backpressure and mid-operation reset sequences, and random sweeps on
// N=7/W=3 and N=32/W=32 instances, all checked through a scoreboard queue.
module tb_serial_subtractor;
`ifdef SERIAL_SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b1;
  logic [2:0]  in_valid = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        r0, v0, bo0;
  logic [31:0] d0;
  logic        r1, v1, bo1;
  logic [6:0]  d1;
  logic        r2, v2, bo2;
  logic [31:0] d2;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  logic [32:0] sbq[$];
  int lat_tab[3] = '{8, 3, 1};

  always #5 clk = ~clk;

  serial_subtractor #(.N(32), .W(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(r0), .a(a), .b(b),
    .out_valid(v0), .out_ready(out_ready), .diff(d0), .borrow(bo0));

  serial_subtractor #(.N(7), .W(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(r1), .a(a[6:0]), .b(b[6:0]),
    .out_valid(v1), .out_ready(out_ready), .diff(d1), .borrow(bo1));

  serial_subtractor #(.N(32), .W(32)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(r2), .a(a), .b(b),
    .out_valid(v2), .out_ready(out_ready), .diff(d2), .borrow(bo2));

  logic        s_ready, s_valid, s_borrow;
  logic [31:0] s_diff;

  always_comb begin
    s_ready  = r0;
    s_valid  = v0;
    s_borrow = bo0;
    s_diff   = d0;
    case (cur)
      1: begin s_ready = r1; s_valid = v1; s_borrow = bo1; s_diff = {25'd0, d1}; end
      2: begin s_ready = r2; s_valid = v2; s_borrow = bo2; s_diff = d2; end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned subtract at the instance's width, optional clamp.
  function automatic logic [32:0] model(input int sel, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] r;
    logic [7:0]  t;
    if (sel == 1) begin
      t = {1'b0, x[6:0]} - {1'b0, y[6:0]};
      r = {t[7], 25'd0, t[6:0]};
    end else begin
      r = {1'b0, x} - {1'b0, y};
    end
    if (SAT && r[32]) r[31:0] = '0;
    return r;
  endfunction

  // Full transaction: accept, check latency, pop scoreboard, consume.
  task automatic do_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                       input logic [32:0] exp);
    int cyc;
    logic [32:0] e;
    cur = sel;
    a = av;
    b = bv;
    in_valid[sel] = 1'b1;
    #1;
    chk("in_ready_idle", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    sbq.push_back(exp);
    cyc = 0;
    while (!s_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(lat_tab[sel]));
    e = (sbq.size() > 0) ? sbq.pop_front() : 33'h0;
    chk("diff", 64'(s_diff), 64'(e[31:0]));
    chk("borrow", 64'(s_borrow), 64'(e[32]));
    @(posedge clk); #1;
    chk("consumed", 64'(s_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[4];
    logic [32:0] e;
    logic [31:0] ra, rb;
    int errs_before;

    vt[0] = '{32'd100,        32'd30,         32'd70,                        1'b0};
    vt[1] = '{32'd0,          32'd1,          SAT ? 32'd0 : 32'hFFFF_FFFF,   1'b1};
    vt[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,                         1'b0};
    vt[3] = '{32'd0,          32'hFFFF_FFFF,  SAT ? 32'd0 : 32'd1,           1'b1};

    // Reset held for three cycles.
    cur = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(r0), 64'd1);
    chk("rst_out_valid", 64'(v0), 64'd0);
    chk("rst_diff", 64'(d0), 64'd0);
    chk("rst_borrow", 64'(bo0), 64'd0);
    @(posedge clk); #1;
    chk("idle_out_valid", 64'(v0), 64'd0);

    // Table vectors on N=32, W=4.
    for (int i = 0; i < 4; i++) do_op(0, vt[i].a, vt[i].b, {vt[i].bo, vt[i].d});

    // Backpressure: hold DONE for 5 cycles while in_valid pulses with new operands.
    out_ready = 1'b0;
    cur = 0;
    a = 32'd1000;
    b = 32'd1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    sbq.push_back({1'b0, 32'd999});
    repeat (8) @(posedge clk);
    #1;
    chk("bp_valid_rise", 64'(v0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      in_valid[0] = ~in_valid[0];
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(v0), 64'd1);
      chk("bp_in_ready", 64'(r0), 64'd0);
      chk("bp_diff", 64'(d0), 64'(sbq[0][31:0]));
      chk("bp_borrow", 64'(bo0), 64'(sbq[0][32]));
    end
    // Consume with in_valid still high: no capture on the consuming edge.
    in_valid[0] = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    void'(sbq.pop_front());
    chk("bp_release_valid", 64'(v0), 64'd0);
    chk("bp_no_capture", 64'(r0), 64'd1);
    do_op(0, 32'd50, 32'd8, {1'b0, 32'd42});

    // Reset while RUN is on slice 3.
    a = 32'd123;
    b = 32'd45;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", 64'(r0), 64'd1);
    chk("mid_rst_out_valid", 64'(v0), 64'd0);
    chk("mid_rst_diff", 64'(d0), 64'd0);
    chk("mid_rst_borrow", 64'(bo0), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_no_result", 64'(v0), 64'd0);
    do_op(0, 32'd5, 32'd7, {1'b1, SAT ? 32'd0 : 32'hFFFF_FFFE});

    // Random sweeps plus the all-ones pair; stop each sweep at the first mismatch.
    for (int sel = 1; sel <= 2; sel++) begin
      errs_before = errors;
      for (int i = 0; i <= 100; i++) begin
        if (i == 100) begin
          ra = 32'hFFFF_FFFF;
          rb = 32'hFFFF_FFFF;
        end else begin
          ra = $urandom;
          rb = $urandom;
        end
        e = model(sel, ra, rb);
        do_op(sel, ra, rb, e);
        if (errors != errs_before) break;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
